// File: rtl/maze_rate_gen.sv
// maze_rate_gen: CH independent programmable rate channels from one clock.
// Each channel counts enabled cycles up to its divisor and emits a toggle or tick output.
module maze_rate_gen #(
   parameter int           CH       = 4,
   parameter int           W        = 32,
   parameter logic [W-1:0] DEF_DIV  = 32'd2000000,
   parameter logic         DEF_MODE = 1'b0,
   parameter int           SW       = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic          cin,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [SW-1:0] wr_sel,
   input  logic [W-1:0]  wr_div,
   input  logic          wr_mode,
   input  logic [CH-1:0] ch_en,
   input  logic          resync,
   output logic [CH-1:0] cout,
   output logic [CH-1:0] tick
);

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0]  cnt_q [CH];
   logic [W-1:0]  cnt_d [CH];
   logic [W-1:0]  div_q [CH];
   logic [W-1:0]  div_d [CH];
   logic [CH-1:0] mode_q, mode_d;
   logic [CH-1:0] cout_q, cout_d;
   logic [CH-1:0] tick_q, tick_d;
   logic [CH-1:0] wr_hit_s;
   logic [CH-1:0] term_s;

   // A divisor of zero behaves as one so the channel ticks every enabled cycle.
   function automatic logic [W-1:0] eff_div(input logic [W-1:0] d);
      return (d == '0) ? ONE : d;
   endfunction

   // Next-state for every channel: resync beats write beats count.
   always_comb begin
      for (int i = 0; i < CH; i++) begin
         cnt_d[i]    = cnt_q[i];
         div_d[i]    = div_q[i];
         mode_d[i]   = mode_q[i];
         cout_d[i]   = cout_q[i];
         tick_d[i]   = 1'b0;
         wr_hit_s[i] = wr_en && (wr_sel == SW'(i));
         // >= lets a freshly lowered divisor terminate on the next enabled edge
         term_s[i]   = (cnt_q[i] >= (eff_div(div_q[i]) - ONE));

         if (wr_hit_s[i]) begin
            div_d[i]  = wr_div;
            mode_d[i] = wr_mode;
         end else begin
            div_d[i]  = div_q[i];
            mode_d[i] = mode_q[i];
         end

         if (resync || wr_hit_s[i]) begin
            cnt_d[i]  = '0;
            tick_d[i] = 1'b0;
            cout_d[i] = 1'b0;
         end else if (ch_en[i] && term_s[i]) begin
            cnt_d[i]  = '0;
            tick_d[i] = 1'b1;
            cout_d[i] = mode_q[i] ? 1'b1 : ~cout_q[i];
         end else if (ch_en[i]) begin
            cnt_d[i]  = cnt_q[i] + ONE;
            tick_d[i] = 1'b0;
            cout_d[i] = mode_q[i] ? 1'b0 : cout_q[i];
         end else begin
            cnt_d[i]  = cnt_q[i];
            tick_d[i] = 1'b0;
            cout_d[i] = mode_q[i] ? 1'b0 : cout_q[i];
         end
      end
   end

   // Channel state registers with synchronous reset to the default program.
   always_ff @(posedge cin) begin
      if (rst) begin
         for (int i = 0; i < CH; i++) begin
            cnt_q[i] <= '0;
            div_q[i] <= DEF_DIV;
         end
         mode_q <= {CH{DEF_MODE}};
         cout_q <= '0;
         tick_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         div_q  <= div_d;
         mode_q <= mode_d;
         cout_q <= cout_d;
         tick_q <= tick_d;
      end
   end

   assign cout = cout_q;
   assign tick = tick_q;

endmodule

// File: tb/tb_maze_rate_gen.sv
// Bench for maze_rate_gen: directed vector table, corner sequences, and random
// stimulus checked against an enabled-cycle-count reference model.
module tb_maze_rate_gen;

   localparam int CH = 5;
   localparam int W  = 8;
   localparam int SW = 3;
   localparam logic [W-1:0] DEF_DIV = 8'd4;

   logic          cin = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic [SW-1:0] wr_sel = 3'd0;
   logic [W-1:0]  wr_div = 8'd0;
   logic          wr_mode = 1'b0;
   logic [CH-1:0] ch_en = 5'h1F;
   logic          resync = 1'b0;
   logic [CH-1:0] cout, tick;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: enabled edges since last restart, plus programmed divisor/mode.
   int            mn    [CH];
   int            mdiv  [CH];
   logic          mmode [CH];
   logic [CH-1:0] etick, ecout;

   typedef struct packed {
      logic          we;
      logic [SW-1:0] sel;
      logic [W-1:0]  dv;
      logic          md;
      logic [CH-1:0] en;
      logic          rs;
      logic [CH-1:0] et;
      logic [CH-1:0] ec;
   } vec_t;
   vec_t tbl [1:20];

   maze_rate_gen #(.CH(CH), .W(W), .DEF_DIV(DEF_DIV), .DEF_MODE(1'b0)) dut (
      .cin(cin), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_div(wr_div),
      .wr_mode(wr_mode), .ch_en(ch_en), .resync(resync), .cout(cout), .tick(tick)
   );

   always #5 cin = ~cin;

   function automatic vec_t mkv(input logic we, input logic [SW-1:0] sel, input logic [W-1:0] dv,
                                input logic md, input logic [CH-1:0] et, input logic [CH-1:0] ec);
      vec_t v;
      v.we = we; v.sel = sel; v.dv = dv; v.md = md;
      v.en = 5'h1F; v.rs = 1'b0; v.et = et; v.ec = ec;
      return v;
   endfunction

   task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   task automatic model_update();
      int de;
      logic hit;
      for (int i = 0; i < CH; i++) begin
         de  = (mdiv[i] == 0) ? 1 : mdiv[i];
         hit = wr_en && (int'(wr_sel) == i);
         if (rst) begin
            mn[i] = 0; mdiv[i] = int'(DEF_DIV); mmode[i] = 1'b0;
            etick[i] = 1'b0; ecout[i] = 1'b0;
         end else begin
            if (hit) begin
               mdiv[i] = int'(wr_div); mmode[i] = wr_mode;
            end
            if (resync || hit) begin
               mn[i] = 0; etick[i] = 1'b0; ecout[i] = 1'b0;
            end else if (ch_en[i]) begin
               mn[i]++;
               etick[i] = ((mn[i] % de) == 0);
               ecout[i] = mmode[i] ? etick[i] : (((mn[i] / de) % 2) == 1);
            end else begin
               etick[i] = 1'b0;
               ecout[i] = mmode[i] ? 1'b0 : (((mn[i] / de) % 2) == 1);
            end
         end
      end
   endtask

   task automatic step(input logic we, input logic [SW-1:0] sel, input logic [W-1:0] dv,
                       input logic md, input logic [CH-1:0] en, input logic rs, input logic r);
      wr_en = we; wr_sel = sel; wr_div = dv; wr_mode = md; ch_en = en; resync = rs; rst = r;
      @(posedge cin);
      model_update();
      #1;
      check("model_tick", tick, etick);
      check("model_cout", cout, ecout);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 3'd0, 8'd0, 1'b0, 5'h1F, 1'b0, 1'b0);
   endtask

   initial begin
      // Cycle k of the table is the state after the k-th edge following reset release.
      for (int k = 1; k <= 20; k++) tbl[k] = mkv(1'b0, 3'd0, 8'd0, 1'b0, 5'h00, 5'h00);
      tbl[4]  = mkv(1'b0, 3'd0, 8'd0, 1'b0, 5'h1F, 5'h1F);
      for (int k = 5; k <= 7; k++) tbl[k] = mkv(1'b0, 3'd0, 8'd0, 1'b0, 5'h00, 5'h1F);
      tbl[8]  = mkv(1'b0, 3'd0, 8'd0, 1'b0, 5'h1F, 5'h00);
      tbl[10] = mkv(1'b1, 3'd2, 8'd3, 1'b1, 5'h00, 5'h00);
      tbl[12] = mkv(1'b0, 3'd0, 8'd0, 1'b0, 5'b11011, 5'b11011);
      tbl[13] = mkv(1'b0, 3'd0, 8'd0, 1'b0, 5'b00100, 5'b11111);
      tbl[14] = mkv(1'b0, 3'd0, 8'd0, 1'b0, 5'b00000, 5'b11011);
      tbl[15] = mkv(1'b0, 3'd0, 8'd0, 1'b0, 5'b00000, 5'b11011);
      tbl[16] = mkv(1'b0, 3'd0, 8'd0, 1'b0, 5'b11111, 5'b00100);
      tbl[19] = mkv(1'b0, 3'd0, 8'd0, 1'b0, 5'b00100, 5'b00100);
      tbl[20] = mkv(1'b0, 3'd0, 8'd0, 1'b0, 5'b11011, 5'b11011);

      step(1'b0, 3'd0, 8'd0, 1'b0, 5'h1F, 1'b0, 1'b1);
      step(1'b0, 3'd0, 8'd0, 1'b0, 5'h1F, 1'b0, 1'b1);
      check("reset_tick", tick, 5'h00);
      check("reset_cout", cout, 5'h00);

      for (int k = 1; k <= 20; k++) begin
         step(tbl[k].we, tbl[k].sel, tbl[k].dv, tbl[k].md, tbl[k].en, tbl[k].rs, 1'b0);
         check($sformatf("tbl_tick_c%0d", k), tick, tbl[k].et);
         check($sformatf("tbl_cout_c%0d", k), cout, tbl[k].ec);
      end

      // div=0 on ch1: tick held high every cycle after the write.
      step(1'b1, 3'd1, 8'd0, 1'b0, 5'h1F, 1'b0, 1'b0);
      check("div0_clear", {4'd0, tick[1]}, 5'd0);
      for (int k = 0; k < 5; k++) begin
         idle(1);
         check("div0_tick_high", {4'd0, tick[1]}, 5'd1);
      end

      // Out-of-range select must leave every channel untouched.
      step(1'b1, 3'd5, 8'd7, 1'b1, 5'h1F, 1'b0, 1'b0);
      check("badsel_ch1_tick", {4'd0, tick[1]}, 5'd1);
      idle(3);

      // Pause ch0 at cnt=2 with cout high, then resume.
      step(1'b0, 3'd0, 8'd0, 1'b0, 5'h1F, 1'b1, 1'b0);
      check("resync1_tick", tick, 5'h00);
      check("resync1_cout", cout, 5'h00);
      idle(6);
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 3'd0, 8'd0, 1'b0, 5'b11110, 1'b0, 1'b0);
         check("pause_cout0", {4'd0, cout[0]}, 5'd1);
         check("pause_tick0", {4'd0, tick[0]}, 5'd0);
      end
      idle(1);
      check("resume1_tick0", {4'd0, tick[0]}, 5'd0);
      idle(1);
      check("resume2_tick0", {4'd0, tick[0]}, 5'd1);
      check("resume2_cout0", {4'd0, cout[0]}, 5'd0);

      // Resync out-of-phase channels 0,3,4 (all div 4) back into alignment.
      step(1'b0, 3'd0, 8'd0, 1'b0, 5'h1F, 1'b1, 1'b0);
      check("resync2_tick", tick, 5'h00);
      check("resync2_cout", cout, 5'h00);
      for (int k = 1; k <= 4; k++) begin
         idle(1);
         check($sformatf("inphase_c%0d", k), tick & 5'b11001, (k == 4) ? 5'b11001 : 5'b00000);
      end

      // rst together with write and resync: write discarded, defaults restored.
      idle(2);
      step(1'b1, 3'd2, 8'd9, 1'b1, 5'h1F, 1'b1, 1'b1);
      check("rstmix_tick", tick, 5'h00);
      check("rstmix_cout", cout, 5'h00);
      for (int k = 1; k <= 4; k++) begin
         idle(1);
         check($sformatf("rstdef_tick_c%0d", k), tick, (k == 4) ? 5'h1F : 5'h00);
      end
      check("rstdef_cout", cout, 5'h1F);

      // All-ones divisor: full count range without overflow.
      step(1'b1, 3'd3, 8'hFF, 1'b0, 5'h1F, 1'b0, 1'b0);
      idle(600);

      // Randomized traffic against the reference model.
      for (int k = 0; k < 1500; k++) begin
         logic          we, rs, r, md;
         logic [SW-1:0] sel;
         logic [W-1:0]  dv;
         logic [CH-1:0] en;
         we  = ($urandom_range(0, 9) == 0);
         rs  = ($urandom_range(0, 39) == 0);
         r   = ($urandom_range(0, 199) == 0);
         md  = 1'($urandom_range(0, 1));
         sel = 3'($urandom_range(0, 7));
         dv  = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
         en  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h1F;
         step(we, sel, dv, md, en, rs, r);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
